// File: rtl/riscv_defs_pkg.sv
// ============================================================================
// riscv_defs_pkg : RV32I opcode/funct constants, control-bus and scoreboard types
// Revision: 2.0
// ============================================================================
`default_nettype none

package riscv_defs_pkg;

    localparam logic [6:0] OP_LUI       = 7'b0110111;
    localparam logic [6:0] OP_AUIPC     = 7'b0010111;
    localparam logic [6:0] OP_JAL       = 7'b1101111;
    localparam logic [6:0] OP_JALR      = 7'b1100111;
    localparam logic [6:0] OP_BRANCH    = 7'b1100011;
    localparam logic [6:0] OP_LOAD      = 7'b0000011;
    localparam logic [6:0] OP_STORE     = 7'b0100011;
    localparam logic [6:0] OP_IMMEDIATE = 7'b0010011;
    localparam logic [6:0] OP_R_R       = 7'b0110011;
    localparam logic [6:0] OP_FENCE     = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM    = 7'b1110011;

    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    localparam logic [2:0] F3_ADD = 3'b000;
    localparam logic [2:0] F3_SLL = 3'b001;
    localparam logic [2:0] F3_SR  = 3'b101;
    localparam logic [2:0] ALU_ADD = F3_ADD;

    typedef enum logic [1:0] {
        SRC1_RS1  = 2'd0,
        SRC1_PC   = 2'd1,
        SRC1_ZERO = 2'd2
    } alu_src1_e;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_sel_e;

    typedef enum logic [1:0] {
        WB_ALU = 2'd0,
        WB_MEM = 2'd1,
        WB_PC4 = 2'd2
    } wb_sel_e;

    typedef struct packed {
        logic       illegal;
        logic [4:0] rd;
        logic       rf_wr;
        logic [4:0] rs1;
        logic       rs1_use;
        logic [4:0] rs2;
        logic       rs2_use;
        alu_src1_e  alu_src1;
        logic       alu_src2;      // 0 = rs2, 1 = immediate
        imm_sel_e   imm_sel;
        logic [2:0] alu_op;
        logic       arith_logic;
        wb_sel_e    wb_sel;
        logic       dmem_rd;
        logic       dmem_wr;
        logic [2:0] ld_st_funct3;
        logic       branch;
        logic [2:0] br_funct3;
        logic       jump;
        logic       jalr;
    } ctrl_bus_v2_t;

    typedef struct packed {
        logic       valid;
        logic [4:0] rd;
        logic       is_load;
    } sb_entry_t;

endpackage

`default_nettype wire

// File: rtl/rv32i_decoder.sv
// ============================================================================
// rv32i_decoder : combinational RV32I decode with illegal-encoding detection
// Revision: 2.0
// ============================================================================
`default_nettype none

module rv32i_decoder
    import riscv_defs_pkg::*;
(
    input  logic [31:0]  instruction,
    output ctrl_bus_v2_t ctrl
);

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic       illegal;

    assign opcode = instruction[6:0];
    assign funct3 = instruction[14:12];
    assign funct7 = instruction[31:25];

    always_comb begin
        ctrl          = '0;
        illegal       = 1'b0;
        ctrl.rd       = instruction[11:7];
        ctrl.rs1      = instruction[19:15];
        ctrl.rs2      = instruction[24:20];
        ctrl.alu_src1 = SRC1_RS1;
        ctrl.imm_sel  = IMM_I;
        ctrl.wb_sel   = WB_ALU;
        ctrl.alu_op   = ALU_ADD;

        case (opcode)
            OP_R_R: begin
                ctrl.rs1_use     = 1'b1;
                ctrl.rs2_use     = 1'b1;
                ctrl.rf_wr       = 1'b1;
                ctrl.alu_op      = funct3;
                ctrl.arith_logic = funct7[5];
                if (funct7 != F7_BASE && funct7 != F7_ALT)
                    illegal = 1'b1;
                if (funct7 == F7_ALT && funct3 != F3_ADD && funct3 != F3_SR)
                    illegal = 1'b1;
            end
            OP_IMMEDIATE: begin
                ctrl.rs1_use  = 1'b1;
                ctrl.rf_wr    = 1'b1;
                ctrl.alu_src2 = 1'b1;
                ctrl.alu_op   = funct3;
                // Only the shift-right form carries an ALT bit; elsewhere it is immediate data
                ctrl.arith_logic = (funct3 == F3_SR) ? funct7[5] : 1'b0;
                if (funct3 == F3_SLL && funct7 != F7_BASE)
                    illegal = 1'b1;
                if (funct3 == F3_SR && funct7 != F7_BASE && funct7 != F7_ALT)
                    illegal = 1'b1;
            end
            OP_LOAD: begin
                ctrl.rs1_use      = 1'b1;
                ctrl.rf_wr        = 1'b1;
                ctrl.alu_src2     = 1'b1;
                ctrl.wb_sel       = WB_MEM;
                ctrl.dmem_rd      = 1'b1;
                ctrl.ld_st_funct3 = funct3;
            end
            OP_STORE: begin
                ctrl.rs1_use      = 1'b1;
                ctrl.rs2_use      = 1'b1;
                ctrl.alu_src2     = 1'b1;
                ctrl.imm_sel      = IMM_S;
                ctrl.dmem_wr      = 1'b1;
                ctrl.ld_st_funct3 = funct3;
            end
            OP_BRANCH: begin
                ctrl.rs1_use   = 1'b1;
                ctrl.rs2_use   = 1'b1;
                ctrl.imm_sel   = IMM_B;
                ctrl.branch    = 1'b1;
                ctrl.br_funct3 = funct3;
            end
            OP_JAL: begin
                ctrl.rf_wr    = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.alu_src1 = SRC1_PC;
                ctrl.alu_src2 = 1'b1;
                ctrl.imm_sel  = IMM_J;
                ctrl.wb_sel   = WB_PC4;
            end
            OP_JALR: begin
                ctrl.rs1_use  = 1'b1;
                ctrl.rf_wr    = 1'b1;
                ctrl.jump     = 1'b1;
                ctrl.jalr     = 1'b1;
                ctrl.alu_src1 = SRC1_PC;
                ctrl.alu_src2 = 1'b1;
                ctrl.wb_sel   = WB_PC4;
            end
            OP_LUI: begin
                ctrl.rf_wr    = 1'b1;
                ctrl.alu_src1 = SRC1_ZERO;
                ctrl.alu_src2 = 1'b1;
                ctrl.imm_sel  = IMM_U;
            end
            OP_AUIPC: begin
                ctrl.rf_wr    = 1'b1;
                ctrl.alu_src1 = SRC1_PC;
                ctrl.alu_src2 = 1'b1;
                ctrl.imm_sel  = IMM_U;
            end
            OP_FENCE, OP_SYSTEM: ;
            default: illegal = 1'b1;   // also catches opcode[1:0] != 2'b11
        endcase

        if (ctrl.rd == 5'd0)
            ctrl.rf_wr = 1'b0;
        if (illegal) begin
            ctrl.rf_wr   = 1'b0;
            ctrl.dmem_rd = 1'b0;
            ctrl.dmem_wr = 1'b0;
            ctrl.branch  = 1'b0;
            ctrl.jump    = 1'b0;
            ctrl.jalr    = 1'b0;
        end
        ctrl.illegal = illegal;
    end

endmodule

`default_nettype wire

// File: rtl/pipelined_control_unit.sv
// ============================================================================
// pipelined_control_unit : registered decode stage with RAW scoreboard and handshakes
// Revision: 2.0
// ============================================================================
`default_nettype none

module pipelined_control_unit
    import riscv_defs_pkg::*;
#(
    parameter int NB_WORD      = 32,
    parameter int NB_REG_ADDR  = 5,
    parameter int HAZARD_DEPTH = 3,
    parameter int FORWARDING   = 1
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic [NB_WORD-1:0] i_instruction,
    input  logic               i_valid,
    output logic               o_ready,
    output ctrl_bus_v2_t       o_control_bus,
    output logic               o_valid,
    input  logic               i_ready,
    input  logic               i_flush,
    output logic               o_stall
);

    ctrl_bus_v2_t           dec;
    sb_entry_t              sb [HAZARD_DEPTH];
    logic                   hazard;
    logic                   accept;
    logic [NB_REG_ADDR-1:0] rs1_addr;
    logic [NB_REG_ADDR-1:0] rs2_addr;

    rv32i_decoder u_decoder (
        .instruction (i_instruction[31:0]),
        .ctrl        (dec)
    );

    assign rs1_addr = dec.rs1;
    assign rs2_addr = dec.rs2;

    // With forwarding only a load sitting in the output register cannot be bypassed
    always_comb begin
        hazard = 1'b0;
        for (int k = 0; k < HAZARD_DEPTH; k++) begin
            if (sb[k].valid && (FORWARDING == 0 || (k == 0 && sb[0].is_load))) begin
                if (dec.rs1_use && rs1_addr != '0 && rs1_addr == sb[k].rd)
                    hazard = 1'b1;
                if (dec.rs2_use && rs2_addr != '0 && rs2_addr == sb[k].rd)
                    hazard = 1'b1;
            end
        end
    end

    assign o_ready = i_ready & ~hazard & ~i_flush;
    assign accept  = i_valid & o_ready;
    assign o_stall = i_valid & i_ready & hazard & ~i_flush;

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_valid       <= 1'b0;
            o_control_bus <= '0;
            for (int k = 0; k < HAZARD_DEPTH; k++)
                sb[k] <= '0;
        end else if (i_ready) begin
            o_valid <= accept;
            if (accept)
                o_control_bus <= dec;
            sb[0] <= sb_entry_t'{valid: accept & dec.rf_wr, rd: dec.rd, is_load: dec.dmem_rd};
            // A flushed instruction advances as an invalid entry
            for (int k = 1; k < HAZARD_DEPTH; k++)
                sb[k] <= (k == 1 && i_flush) ? '0 : sb[k-1];
        end else if (i_flush) begin
            o_valid      <= 1'b0;
            sb[0].valid  <= 1'b0;
        end
    end

endmodule

`default_nettype wire
